// File: rtl/vote_session_ctrl_pkg.sv
// Shared types for the voting session controller: FSM state encoding and
// a small helper to count yes flags.
package vote_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OPEN  = 2'd1,
        S_TALLY = 2'd2,
        S_SHOW  = 2'd3
    } state_t;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/vote_session_ctrl_if.sv
// Board-side bundle of the session controller: keys/buttons in, LEDs out.
interface vote_session_ctrl_if;

    logic       start;
    logic       cancel;
    logic       vote_a;
    logic       vote_b;
    logic       vote_c;
    logic       busy;
    logic       window_open;
    logic [2:0] voted;
    logic [1:0] yes_cnt;
    logic       result;
    logic       result_valid;

    modport master (
        output start, cancel, vote_a, vote_b, vote_c,
        input  busy, window_open, voted, yes_cnt, result, result_valid
    );

    modport slave (
        input  start, cancel, vote_a, vote_b, vote_c,
        output busy, window_open, voted, yes_cnt, result, result_valid
    );

endinterface

// File: rtl/vote_session_ctrl_three_voter.sv
// Combinational 2-of-3 majority element used as the session's decision logic.
module three_voter (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic y_o
);

    assign y_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/vote_session_ctrl.sv
// Session sequencer: opens a timed voting window, latches sticky yes votes,
// registers the majority verdict and holds it for a fixed display period.
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int WIN_CYCLES  = 1000,
    parameter int SHOW_CYCLES = 500
) (
    input  logic              clk,
    input  logic              rst,
    vote_session_ctrl_if.slave bus
);

    localparam int MAX_CYCLES = (WIN_CYCLES > SHOW_CYCLES) ? WIN_CYCLES : SHOW_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WIN_LOAD  = CNT_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       voted_q, voted_d;
    logic [1:0]       yes_cnt_q;
    logic             result_q;
    logic             majority;
    logic [2:0]       votes;
    logic             cnt_zero;

    assign votes    = {bus.vote_c, bus.vote_b, bus.vote_a};
    assign cnt_zero = (cnt_q == '0);

    three_voter u_voter (
        .a_i (voted_q[0]),
        .b_i (voted_q[1]),
        .c_i (voted_q[2]),
        .y_o (majority)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Cancel outranks both expiry and the all-voted early close.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_OPEN;
            end
            S_OPEN: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else if (cnt_zero || (&(voted_q | votes))) begin
                    state_d = S_TALLY;
                end
            end
            S_TALLY: state_d = S_SHOW;
            S_SHOW: begin
                if (cnt_zero) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One down-counter serves both the voting window and the display period.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE:  if (bus.start) cnt_q <= WIN_LOAD;
                S_OPEN:  if (!cnt_zero) cnt_q <= cnt_q - 1'b1;
                S_TALLY: cnt_q <= SHOW_LOAD;
                S_SHOW:  if (!cnt_zero) cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= '0;
            endcase
        end
    end

    always_comb begin
        voted_d = voted_q;
        if (state_q == S_IDLE && bus.start) begin
            voted_d = 3'b000;
        end else if (state_q == S_OPEN) begin
            voted_d = bus.cancel ? 3'b000 : (voted_q | votes);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            voted_q   <= 3'b000;
            yes_cnt_q <= 2'd0;
            result_q  <= 1'b0;
        end else begin
            voted_q   <= voted_d;
            yes_cnt_q <= popcount3(voted_d);
            if (state_q == S_TALLY) result_q <= majority;
        end
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.window_open  = (state_q == S_OPEN);
    assign bus.result_valid = (state_q == S_SHOW);
    assign bus.voted        = voted_q;
    assign bus.yes_cnt      = yes_cnt_q;
    assign bus.result       = result_q;

endmodule
